// File: rtl/apb_uart_rx_slave_pkg.sv
// Shared definitions for the APB UART receive slave.
//   - register byte offsets (RXDATA, STATUS, CTRL)
//   - STATUS / CTRL bit positions
//   - receive FSM state encoding
package apb_uart_pkg;

  localparam logic [4:0] RXDATA_OFF = 5'h00;
  localparam logic [4:0] STATUS_OFF = 5'h04;
  localparam logic [4:0] CTRL_OFF   = 5'h08;

  // STATUS bits; count occupies [7:4]
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_COUNT_LSB = 4;

  // CTRL bits; the two clear bits are write-only strobes
  localparam int CTRL_RX_EN    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CLR_OVF  = 2;
  localparam int CTRL_CLR_FERR = 3;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/apb_uart_rx_slave_if.sv
// APB bus bundle for the UART receive slave.
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0), then
// access cycles (psel=1, penable=1) held by the master until the slave returns
// pready=1 for exactly one cycle; prdata and pslverr are only meaningful in
// that pready cycle.
//   master modport: drives psel/penable/pwrite/paddr/pwdata
//   slave modport : drives prdata/pready/pslverr
interface apb_uart_rx_slave_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_uart_rx_slave_rx_core.sv
// UART 8N1 deserialiser: two-flop synchroniser, bit timer, receive FSM.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rx            raw serial line (idle high)
//   rx_en         receiver enable; dropping it aborts any frame in progress
//   rx_byte       last assembled byte (valid with rx_valid)
//   rx_valid      1-cycle pulse: good stop bit seen
//   rx_frame_err  1-cycle pulse: stop bit was low, byte discarded
module uart_rx_core
  import apb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_en,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_sync;
  rx_state_e        state;
  rx_state_e        state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             half_tick;
  logic             bit_tick;

  // Synchroniser resets to the idle level so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign half_tick = (cnt == HALF_LAST);
  assign bit_tick  = (cnt == FULL_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (!rx_en) begin
      state_next = RX_IDLE;
    end else begin
      case (state)
        RX_IDLE:  if (!rx_sync) state_next = RX_START;
        RX_START: if (half_tick) state_next = rx_sync ? RX_IDLE : RX_DATA;
        RX_DATA:  if (bit_tick && bit_idx == 3'd7) state_next = RX_STOP;
        RX_STOP:  if (bit_tick) state_next = RX_IDLE;
        default:  state_next = RX_IDLE;
      endcase
    end
  end

  // Bit timer restarts on every state change and on every bit boundary, so
  // after the half-bit start check all samples land mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state == RX_IDLE || state_next != state || bit_tick) cnt <= '0;
      else                                                    cnt <= cnt + CNT_W'(1);

      if (state != RX_DATA)  bit_idx <= '0;
      else if (bit_tick)     bit_idx <= bit_idx + 3'd1;

      if (state == RX_DATA && bit_tick) shift <= {rx_sync, shift[7:1]};
    end
  end

  // Outputs
  always_comb begin
    rx_byte      = shift;
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
    if (state == RX_STOP && bit_tick && rx_en) begin
      rx_valid     = rx_sync;
      rx_frame_err = !rx_sync;
    end
  end

endmodule

// File: rtl/apb_uart_rx_slave.sv
// APB slave exposing a UART receiver through a small byte FIFO.
// Ports:
//   pclk, Reset  clock, synchronous active-high reset
//   apb          APB slave bundle (psel/penable/pwrite/paddr/pwdata in,
//                prdata/pready/pslverr out)
//   rx           serial input, 8N1, LSB first
//   rx_irq       level interrupt: FIFO non-empty and CTRL.irq_en
// Registers: 0x00 RXDATA (RO, pops), 0x04 STATUS (RO), 0x08 CTRL (RW).
module apb_uart_rx_slave
  import apb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                pclk,
  input  logic                Reset,
  apb_uart_rx_slave_if.slave  apb,
  input  logic                rx,
  output logic                rx_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          not_empty;

  logic          rx_en;
  logic          irq_en;
  logic          overflow;
  logic          frame_err;

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_frame_err;

  logic          access;
  logic [4:0]    off;
  logic          sel_rxdata;
  logic          sel_status;
  logic          sel_ctrl;
  logic          pop;
  logic          push;
  logic          ovf_set;
  logic          ctrl_wr;
  logic [31:0]   resp_data;
  logic          resp_err;

  // Address LSBs and upper write-data bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{apb.paddr[1:0], apb.pwdata[31:4]};

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk          (pclk),
    .rst          (Reset),
    .rx           (rx),
    .rx_en        (rx_en),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  assign full      = (count == CW'(FIFO_DEPTH));
  assign not_empty = (count != '0);
  assign rx_irq    = not_empty & irq_en;

  // The first access-phase cycle is the only one that acts; the registered
  // pready then masks the following cycle so nothing happens twice.
  assign access     = apb.psel & apb.penable & ~apb.pready;
  assign off        = {apb.paddr[4:2], 2'b00};
  assign sel_rxdata = (off == RXDATA_OFF);
  assign sel_status = (off == STATUS_OFF);
  assign sel_ctrl   = (off == CTRL_OFF);

  assign pop     = access & ~apb.pwrite & sel_rxdata & not_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign push    = rx_valid & (~full | pop);
  assign ovf_set = rx_valid & full & ~pop;
  assign ctrl_wr = access & apb.pwrite & sel_ctrl;

  always_comb begin
    resp_data = '0;
    resp_err  = 1'b0;
    if (apb.pwrite) begin
      resp_err = ~sel_ctrl;
    end else if (sel_rxdata) begin
      resp_err = ~not_empty;
      if (not_empty) resp_data = {24'd0, mem[rd_ptr]};
    end else if (sel_status) begin
      resp_data[ST_NOT_EMPTY]               = not_empty;
      resp_data[ST_FULL]                    = full;
      resp_data[ST_OVERFLOW]                = overflow;
      resp_data[ST_FRAME_ERR]               = frame_err;
      resp_data[ST_COUNT_LSB +: 4]          = 4'(count);
    end else if (sel_ctrl) begin
      resp_data[CTRL_RX_EN]  = rx_en;
      resp_data[CTRL_IRQ_EN] = irq_en;
    end else begin
      resp_err = 1'b1;
    end
  end

  // APB response: one-cycle registered pready with data/error alongside
  always_ff @(posedge pclk) begin
    if (Reset) begin
      apb.pready  <= 1'b0;
      apb.prdata  <= '0;
      apb.pslverr <= 1'b0;
    end else begin
      apb.pready  <= access;
      apb.prdata  <= access ? resp_data : 32'd0;
      apb.pslverr <= access & resp_err;
    end
  end

  // FIFO storage needs no reset; pointers and count define its contents
  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge pclk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Control and sticky status; a same-cycle set beats a clear
  always_ff @(posedge pclk) begin
    if (Reset) begin
      rx_en     <= 1'b1;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_en  <= apb.pwdata[CTRL_RX_EN];
        irq_en <= apb.pwdata[CTRL_IRQ_EN];
      end
      if (ovf_set)                                 overflow <= 1'b1;
      else if (ctrl_wr && apb.pwdata[CTRL_CLR_OVF]) overflow <= 1'b0;
      if (rx_frame_err)                              frame_err <= 1'b1;
      else if (ctrl_wr && apb.pwdata[CTRL_CLR_FERR]) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_uart_rx_slave.sv
module tb_apb_uart_rx_slave;
  import apb_uart_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic pclk  = 1'b0;
  logic Reset = 1'b1;
  logic rx    = 1'b1;
  logic rx_irq;

  always #5 pclk = ~pclk;

  apb_uart_rx_slave_if bus ();

  apb_uart_rx_slave #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .pclk   (pclk),
    .Reset  (Reset),
    .apb    (bus),
    .rx     (rx),
    .rx_irq (rx_irq)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic        exp_ovf  = 1'b0;
  logic        exp_ferr = 1'b0;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int n;
    n = exp_q.size();
    return {24'd0, 4'(n), exp_ferr, exp_ovf, (n == DEPTH), (n != 0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apb_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    int waits;
    @(negedge pclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wdata;
    @(negedge pclk);
    bus.penable = 1'b1;
    waits = 0;
    do begin
      @(negedge pclk);
      waits++;
    end while (bus.pready !== 1'b1 && waits < 20);
    check("pready_wait", waits, 1);
    rdata = bus.prdata;
    err   = bus.pslverr;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    @(negedge pclk);
    check("pready_one_cycle", {31'd0, bus.pready}, 0);
    check("prdata_after", bus.prdata, 0);
    check("pslverr_after", {31'd0, bus.pslverr}, 0);
  endtask

  task automatic read_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp_data,
                          input logic exp_err);
    logic [31:0] d;
    logic        e;
    apb_xfer(1'b0, addr, 32'd0, d, e);
    check({tag, "_data"}, d, exp_data);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic write_chk(input string tag, input logic [4:0] addr, input logic [31:0] wdata,
                           input logic exp_err);
    logic [31:0] d;
    logic        e;
    apb_xfer(1'b1, addr, wdata, d, e);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  // Pops the scoreboard head if any, otherwise expects the empty-read error
  task automatic read_rxdata(input string tag);
    if (exp_q.size() == 0) read_chk(tag, RXDATA_OFF, 32'd0, 1'b1);
    else                   read_chk(tag, RXDATA_OFF, exp_q.pop_front(), 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_low);
    rx = 1'b0;
    repeat (CPB) @(negedge pclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge pclk);
    end
    if (stop_low) begin
      // Low long enough to be sampled mid-bit, then back to idle
      rx = 1'b0;
      repeat (12) @(negedge pclk);
      rx = 1'b1;
      repeat (CPB) @(negedge pclk);
      exp_ferr = 1'b1;
    end else begin
      rx = 1'b1;
      repeat (CPB) @(negedge pclk);
      if (exp_q.size() < DEPTH) exp_q.push_back({24'd0, b});
      else                      exp_ovf = 1'b1;
    end
    repeat (4) @(negedge pclk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0;  bus.pwdata = '0;
    repeat (3) @(negedge pclk);
    Reset = 1'b0;
    @(negedge pclk);

    // 1: reset state and handshake timing
    check("rst_pready", {31'd0, bus.pready}, 0);
    check("rst_prdata", bus.prdata, 0);
    check("rst_pslverr", {31'd0, bus.pslverr}, 0);
    check("rst_irq", {31'd0, rx_irq}, 0);
    read_chk("t1_status", STATUS_OFF, 32'h0, 1'b0);
    read_chk("t1_ctrl", CTRL_OFF, 32'h1, 1'b0);

    // 2: single byte 0x55
    send_frame(8'h55, 1'b0);
    read_chk("t2_status", STATUS_OFF, exp_status(), 1'b0);
    check("t2_status_const", exp_status(), 32'h11);
    read_rxdata("t2_rxdata");
    read_chk("t2_status_empty", STATUS_OFF, 32'h0, 1'b0);

    // 3: fill FIFO and overflow it
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    send_frame(8'h33, 1'b0);
    send_frame(8'h44, 1'b0);
    send_frame(8'h99, 1'b0);
    read_chk("t3_status", STATUS_OFF, exp_status(), 1'b0);
    for (int i = 0; i < 4; i++) read_rxdata("t3_rxdata");
    write_chk("t3_clr_ovf", CTRL_OFF, 32'h5, 1'b0);
    exp_ovf = 1'b0;
    read_chk("t3_status_clr", STATUS_OFF, exp_status(), 1'b0);
    read_chk("t3_ctrl", CTRL_OFF, 32'h1, 1'b0);

    // 4: framing error, then empty read
    send_frame(8'h3C, 1'b1);
    read_chk("t4_status", STATUS_OFF, exp_status(), 1'b0);
    read_rxdata("t4_empty_rd");
    write_chk("t4_clr_ferr", CTRL_OFF, 32'h9, 1'b0);
    exp_ferr = 1'b0;
    read_chk("t4_status_clr", STATUS_OFF, 32'h0, 1'b0);

    // 5: glitch rejection and illegal accesses
    send_frame(8'h7E, 1'b0);
    rx = 1'b0;
    repeat (4) @(negedge pclk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge pclk);
    read_chk("t5_status_glitch", STATUS_OFF, exp_status(), 1'b0);
    write_chk("t5_wr_rxdata", RXDATA_OFF, 32'hFF, 1'b1);
    write_chk("t5_wr_status", STATUS_OFF, 32'hFF, 1'b1);
    read_chk("t5_rd_unmapped", 5'h0C, 32'h0, 1'b1);
    write_chk("t5_wr_unmapped", 5'h10, 32'hFF, 1'b1);
    read_chk("t5_status_same", STATUS_OFF, exp_status(), 1'b0);
    read_chk("t5_ctrl_same", CTRL_OFF, 32'h1, 1'b0);
    read_rxdata("t5_rxdata");

    // 6: interrupt, then reset mid-frame
    write_chk("t6_ctrl_wr", CTRL_OFF, 32'h3, 1'b0);
    read_chk("t6_ctrl_rd", CTRL_OFF, 32'h3, 1'b0);
    check("t6_irq_before", {31'd0, rx_irq}, 0);
    send_frame(8'hA5, 1'b0);
    check("t6_irq_after", {31'd0, rx_irq}, 1);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge pclk);
    Reset = 1'b1;
    rx    = 1'b1;
    @(negedge pclk);
    Reset = 1'b0;
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    check("t6_rst_irq", {31'd0, rx_irq}, 0);
    check("t6_rst_pready", {31'd0, bus.pready}, 0);
    check("t6_rst_prdata", bus.prdata, 0);
    check("t6_rst_pslverr", {31'd0, bus.pslverr}, 0);
    read_chk("t6_rst_status", STATUS_OFF, 32'h0, 1'b0);
    read_chk("t6_rst_ctrl", CTRL_OFF, 32'h1, 1'b0);
    send_frame(8'hC3, 1'b0);
    read_rxdata("t6_recover");
    read_chk("t6_final_status", STATUS_OFF, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound in case a wait loop never resolves
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
